// File: rtl/aos_arb_pkg.sv
// Shared types and default parameter values for the aos request arbiter.
package aos_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   localparam int DEF_NUM_REQ        = 2;
   localparam int DEF_AOS_ADDR_WIDTH = 1;
   localparam int DEF_AXI_DATA_WIDTH = 32;
   localparam int DEF_RD_LATENCY     = 1;
   localparam int DEF_TIMEOUT        = 255;

   // Width of a requester index; a lone requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aos_rr_pick.sv
// Round-robin winner selection: the first set request at or after the
// pointer, wrapping past the top requester back to zero.
module aos_rr_pick
   import aos_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] onehot_o,
   output logic               any_o
);

   // Scan requesters in rotated order starting at the pointer; first hit wins.
   always_comb begin
      int             j;
      logic [IDX_W-1:0] jx;
      onehot_o = '0;
      any_o    = 1'b0;
      j        = 0;
      jx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr_i) + i;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         jx = IDX_W'(j);
         if (!any_o && req_i[jx]) begin
            any_o        = 1'b1;
            onehot_o[jx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aos_arb.sv
// Arbiter sharing one aos stream port between NUM_REQ requesters: latches
// one winner at a time, issues it on the stream, waits RD_LATENCY cycles for
// read data and returns a one-cycle response to the owner. A stalled issue
// is aborted after TIMEOUT cycles with an error response.
module aos_arb
   import aos_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int AOS_ADDR_WIDTH = DEF_AOS_ADDR_WIDTH,
   parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
   parameter int RD_LATENCY     = DEF_RD_LATENCY,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_i,
   input  logic [NUM_REQ*AOS_ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_REQ-1:0]                  gnt_o,
   output logic [NUM_REQ-1:0]                  rvalid_o,
   output logic [AXI_DATA_WIDTH-1:0]           rdata_o,
   output logic                                err_o,
   output logic                                busy_o,
   output logic                                aos_valid_o,
   output logic [AOS_ADDR_WIDTH-1:0]           aos_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]           aos_wdata_o,
   input  logic                                aos_ready_i,
   input  logic [AXI_DATA_WIDTH-1:0]           aos_rdata_i
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int LAT_W = $clog2(RD_LATENCY + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   // One-hot vector with the bit of requester idx set.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

   // Index of the set bit of a one-hot vector.
   function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   // Requester after idx, wrapping, so the last winner becomes lowest priority.
   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
      if (int'(idx) >= NUM_REQ - 1) begin
         return '0;
      end
      return idx + IDX_W'(1);
   endfunction

   state_e                     state_q;
   logic [IDX_W-1:0]           rr_ptr_q;
   logic [IDX_W-1:0]           win_q;
   logic [LAT_W-1:0]           lat_q;
   logic [TO_W-1:0]            to_q;
   logic                       aos_valid_q;
   logic [AOS_ADDR_WIDTH-1:0]  addr_q;
   logic [AXI_DATA_WIDTH-1:0]  wdata_q;
   logic [AXI_DATA_WIDTH-1:0]  rdata_q;
   logic [NUM_REQ-1:0]         rvalid_q;
   logic                       err_q;

   logic [NUM_REQ-1:0]         pick_oh;
   logic                       pick_any;
   logic [AOS_ADDR_WIDTH-1:0]  sel_addr;
   logic [AXI_DATA_WIDTH-1:0]  sel_wdata;
   logic                       handshake;

   aos_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i    (req_i),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_oh),
      .any_o    (pick_any)
   );

   // Route the winning requester's address and write data (AND-OR mux).
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            sel_addr  = sel_addr  | addr_i[i*AOS_ADDR_WIDTH +: AOS_ADDR_WIDTH];
            sel_wdata = sel_wdata | wdata_i[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
         end
      end
   end

   assign handshake = aos_valid_q & aos_ready_i;

   // Arbitration FSM with its counters, latched request and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         win_q       <= '0;
         lat_q       <= '0;
         to_q        <= '0;
         aos_valid_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rvalid_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         rvalid_q <= '0;
         err_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pick_any) begin
                  win_q       <= oh2idx(pick_oh);
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  to_q        <= '0;
                  aos_valid_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (handshake) begin
                  aos_valid_q <= 1'b0;
                  lat_q       <= LAT_W'(RD_LATENCY);
                  state_q     <= S_WAIT;
               end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                  // Abort: no grant, zero data, error response to the owner.
                  aos_valid_q <= 1'b0;
                  rdata_q     <= '0;
                  rvalid_q    <= onehot(win_q);
                  err_q       <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  to_q <= to_q + TO_W'(1);
               end
            end
            S_WAIT: begin
               if (lat_q == LAT_W'(1)) begin
                  rdata_q  <= aos_rdata_i;
                  lat_q    <= '0;
                  rvalid_q <= onehot(win_q);
                  state_q  <= S_RESP;
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end
            S_RESP: begin
               rr_ptr_q <= ptr_after(win_q);
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Grant is the handshake itself, so it coincides with aos_ready_i rising.
   assign gnt_o       = handshake ? onehot(win_q) : '0;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != S_IDLE);
   assign aos_valid_o = aos_valid_q;
   assign aos_addr_o  = addr_q;
   assign aos_wdata_o = wdata_q;

endmodule

// File: tb/tb_aos_arb.sv
// Bench for aos_arb: instance A (RD_LATENCY=1, TIMEOUT=255) runs the vector
// table, contention, backpressure and reset-in-WAIT; instance B
// (RD_LATENCY=3, TIMEOUT=8) runs the latency and timeout sequences.
module tb_aos_arb;

   localparam int RDL_A = 1;
   localparam int TO_A  = 255;
   localparam int RDL_B = 3;
   localparam int TO_B  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   // Instance A signals
   logic [1:0]  req_a = '0, addr_a = '0;
   logic [63:0] wdata_a = '0;
   logic        ready_a = 1'b1;
   logic [31:0] rdata_a = '0;
   logic [1:0]  gnt_a, rvalid_a, aa_a_unused;
   logic [31:0] rdo_a, aw_a;
   logic        err_a, busy_a, av_a;
   logic [0:0]  aa_a;

   // Instance B signals
   logic [1:0]  req_b = '0, addr_b = '0;
   logic [63:0] wdata_b = '0;
   logic        ready_b = 1'b1;
   logic [31:0] rdata_b = '0;
   logic [1:0]  gnt_b, rvalid_b;
   logic [31:0] rdo_b, aw_b;
   logic        err_b, busy_b, av_b;
   logic [0:0]  aa_b;

   assign aa_a_unused = '0;

   aos_arb #(.NUM_REQ(2), .AOS_ADDR_WIDTH(1), .AXI_DATA_WIDTH(32),
             .RD_LATENCY(RDL_A), .TIMEOUT(TO_A)) u_dut_a (
      .clk(clk), .rst(rst), .req_i(req_a), .addr_i(addr_a), .wdata_i(wdata_a),
      .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdo_a), .err_o(err_a),
      .busy_o(busy_a), .aos_valid_o(av_a), .aos_addr_o(aa_a), .aos_wdata_o(aw_a),
      .aos_ready_i(ready_a), .aos_rdata_i(rdata_a));

   aos_arb #(.NUM_REQ(2), .AOS_ADDR_WIDTH(1), .AXI_DATA_WIDTH(32),
             .RD_LATENCY(RDL_B), .TIMEOUT(TO_B)) u_dut_b (
      .clk(clk), .rst(rst), .req_i(req_b), .addr_i(addr_b), .wdata_i(wdata_b),
      .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdo_b), .err_o(err_b),
      .busy_o(busy_b), .aos_valid_o(av_b), .aos_addr_o(aa_b), .aos_wdata_o(aw_b),
      .aos_ready_i(ready_b), .aos_rdata_i(rdata_b));

   typedef struct {
      logic [1:0]  rv;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic push_a(input logic [1:0] rv, input logic [31:0] d, input logic e, input int c);
      exp_t x;
      x.rv = rv; x.data = d; x.err = e; x.cyc = c;
      qa.push_back(x);
   endtask

   task automatic push_b(input logic [1:0] rv, input logic [31:0] d, input logic e, input int c);
      exp_t x;
      x.rv = rv; x.data = d; x.err = e; x.cyc = c;
      qb.push_back(x);
   endtask

   // Scoreboard A: every response is popped and compared, including its cycle.
   always @(negedge clk) begin
      if (!rst && err_a && rvalid_a == 2'b00) begin
         n_chk++; n_fail++;
         $display("FAIL sb_a_err_alone: err_o=1 rvalid_o=%b", rvalid_a);
      end
      if (!rst && rvalid_a != 2'b00) begin
         if (qa.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_a_unexpected: rvalid_o=%b cycle %0d", rvalid_a, cyc);
         end else begin
            ea = qa.pop_front();
            chk("sb_a_rvalid", 64'(rvalid_a), 64'(ea.rv));
            chk("sb_a_rdata", 64'(rdo_a), 64'(ea.data));
            chk("sb_a_err", 64'(err_a), 64'(ea.err));
            chk("sb_a_cycle", 64'(cyc), 64'(ea.cyc));
         end
      end
   end

   // Scoreboard B
   always @(negedge clk) begin
      if (!rst && rvalid_b != 2'b00) begin
         if (qb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_b_unexpected: rvalid_o=%b cycle %0d", rvalid_b, cyc);
         end else begin
            eb = qb.pop_front();
            chk("sb_b_rvalid", 64'(rvalid_b), 64'(eb.rv));
            chk("sb_b_rdata", 64'(rdo_b), 64'(eb.data));
            chk("sb_b_err", 64'(err_b), 64'(eb.err));
            chk("sb_b_cycle", 64'(cyc), 64'(eb.cyc));
         end
      end
   end

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  addr;
      logic [31:0] wd0, wd1, rd;
      logic [1:0]  exp_gnt;
      logic        exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vt[7];

   initial begin
      int   c0;
      logic got, ok;
      int   icnt;
      logic [1:0] expg;

      // req, addr{a1,a0}, wd0, wd1, rdata, expected grant / addr / wdata
      vt[0] = '{2'b01, 2'b01, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0000_1234, 2'b01, 1'b1, 32'hA5A5_0001};
      vt[1] = '{2'b11, 2'b01, 32'h1111_0000, 32'h2222_0000, 32'h0000_BEEF, 2'b10, 1'b0, 32'h2222_0000};
      vt[2] = '{2'b11, 2'b10, 32'h3333_0000, 32'h4444_0000, 32'hCAFE_0002, 2'b01, 1'b0, 32'h3333_0000};
      vt[3] = '{2'b01, 2'b11, 32'h5555_0000, 32'h6666_0000, 32'h0000_7777, 2'b01, 1'b1, 32'h5555_0000};
      vt[4] = '{2'b10, 2'b10, 32'h8888_0000, 32'h9999_0000, 32'hFFFF_FFFF, 2'b10, 1'b1, 32'h9999_0000};
      vt[5] = '{2'b10, 2'b00, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0F0F_0F0F, 2'b10, 1'b0, 32'hBBBB_0000};
      vt[6] = '{2'b00, 2'b11, 32'hCCCC_0000, 32'hDDDD_0000, 32'h1357_9BDF, 2'b00, 1'b0, 32'h0000_0000};

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_a_ctl", 64'({gnt_a, rvalid_a, err_a, busy_a, av_a, aa_a}), 64'd0);
      chk("reset_a_rdata", 64'(rdo_a), 64'd0);
      chk("reset_a_wdata", 64'(aw_a), 64'd0);
      chk("reset_b_ctl", 64'({gnt_b, rvalid_b, err_b, busy_b, av_b, aa_b}), 64'd0);
      chk("reset_b_rdata", 64'(rdo_b), 64'd0);
      rst = 1'b0;

      // Table-driven single transactions on A, each request held one cycle
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         c0      = cyc;
         req_a   = vt[i].req;
         addr_a  = vt[i].addr;
         wdata_a = {vt[i].wd1, vt[i].wd0};
         rdata_a = vt[i].rd;
         if (vt[i].exp_gnt != 2'b00) push_a(vt[i].exp_gnt, vt[i].rd, 1'b0, c0 + RDL_A + 2);
         @(negedge clk);
         chk($sformatf("vec%0d_idle_busy", i), 64'(busy_a), 64'd0);
         @(posedge clk); #1;
         req_a = 2'b00;
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", i), 64'(gnt_a), 64'(vt[i].exp_gnt));
         chk($sformatf("vec%0d_valid", i), 64'(av_a), 64'(vt[i].exp_gnt != 2'b00));
         if (vt[i].exp_gnt != 2'b00) begin
            chk($sformatf("vec%0d_addr", i), 64'(aa_a), 64'(vt[i].exp_addr));
            chk($sformatf("vec%0d_wdata", i), 64'(aw_a), 64'(vt[i].exp_wdata));
         end
         @(negedge clk);
         chk($sformatf("vec%0d_wait_gnt", i), 64'({gnt_a, av_a}), 64'd0);
         @(negedge clk);
      end

      // Contention: both requesters held, grants must alternate 0,1,0,1
      @(posedge clk); #1;
      req_a   = 2'b11;
      addr_a  = 2'b10;
      wdata_a = {32'hC1C1_C1C1, 32'hC0C0_C0C0};
      for (int k = 0; k < 4; k++) begin
         expg = (k % 2 == 0) ? 2'b01 : 2'b10;
         got  = 1'b0;
         for (int t = 0; t < 12 && !got; t++) begin
            @(negedge clk);
            if (gnt_a != 2'b00) got = 1'b1;
         end
         chk($sformatf("cont%0d_seen", k), 64'(got), 64'd1);
         chk($sformatf("cont%0d_gnt", k), 64'(gnt_a), 64'(expg));
         chk($sformatf("cont%0d_addr", k), 64'(aa_a), 64'(k % 2));
         rdata_a = 32'hD00D_0000 + 32'(k);
         if (got) push_a(expg, 32'hD00D_0000 + 32'(k), 1'b0, cyc + RDL_A + 1);
         if (k == 3) req_a = 2'b00;
      end
      repeat (4) @(negedge clk);

      // Backpressure: ready low 10 cycles, issue held stable, grant on ready
      @(posedge clk); #1;
      ready_a = 1'b0;
      req_a   = 2'b01;
      addr_a  = 2'b01;
      wdata_a = {32'h0, 32'h5555_AAAA};
      rdata_a = 32'h600D_F00D;
      @(posedge clk); #1;
      req_a = 2'b00;
      ok = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (av_a !== 1'b1 || aa_a !== 1'b1 || aw_a !== 32'h5555_AAAA || gnt_a !== 2'b00) ok = 1'b0;
      end
      chk("bp_stable", 64'(ok), 64'd1);
      ready_a = 1'b1;
      #1;
      chk("bp_gnt", 64'(gnt_a), 64'(2'b01));
      push_a(2'b01, 32'h600D_F00D, 1'b0, cyc + RDL_A + 1);
      repeat (3) @(negedge clk);

      // Reset during WAIT: transaction abandoned silently
      @(posedge clk); #1;
      req_a   = 2'b01;
      rdata_a = 32'h7777_7777;
      @(posedge clk); #1;
      req_a = 2'b00;
      @(negedge clk);
      chk("rstw_gnt", 64'(gnt_a), 64'(2'b01));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstw_ctl", 64'({gnt_a, rvalid_a, err_a, busy_a, av_a, aa_a}), 64'd0);
      chk("rstw_rdata", 64'(rdo_a), 64'd0);
      chk("rstw_wdata", 64'(aw_a), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (rvalid_a != 2'b00 || gnt_a != 2'b00 || busy_a) ok = 1'b0;
      end
      chk("rstw_silent", 64'(ok), 64'd1);
      @(posedge clk); #1;
      c0      = cyc;
      req_a   = 2'b10;
      addr_a  = 2'b10;
      wdata_a = {32'h1010_0001, 32'h0};
      rdata_a = 32'h1010_1010;
      push_a(2'b10, 32'h1010_1010, 1'b0, c0 + RDL_A + 2);
      @(posedge clk); #1;
      req_a = 2'b00;
      @(negedge clk);
      chk("rstw_next_gnt", 64'(gnt_a), 64'(2'b10));
      chk("rstw_next_wdata", 64'(aw_a), 64'(32'h1010_0001));
      repeat (3) @(negedge clk);

      // B: RD_LATENCY=3, read data changes every cycle
      @(posedge clk); #1;
      c0      = cyc;
      req_b   = 2'b01;
      addr_b  = 2'b01;
      wdata_b = {32'h0, 32'hB00B_0001};
      rdata_b = 32'hB000_0000 | 32'(cyc);
      push_b(2'b01, 32'hB000_0000 | 32'(c0 + 1 + RDL_B), 1'b0, c0 + RDL_B + 2);
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (t == 1) chk("lat3_gnt", 64'(gnt_b), 64'(2'b01));
         @(posedge clk); #1;
         if (t == 0) req_b = 2'b00;
         rdata_b = 32'hB000_0000 | 32'(cyc);
      end

      // B: timeout with ready held low, pointer now at requester 1
      ready_b = 1'b0;
      c0      = cyc;
      req_b   = 2'b11;
      addr_b  = 2'b10;
      wdata_b = {32'hDEAD_0001, 32'hDEAD_0000};
      rdata_b = 32'h5A5A_5A5A;
      push_b(2'b10, 32'h0, 1'b1, c0 + TO_B + 1);
      @(posedge clk); #1;
      req_b = 2'b00;
      ok   = 1'b1;
      icnt = 0;
      for (int t = 0; t < TO_B + 4; t++) begin
         @(negedge clk);
         if (gnt_b != 2'b00) ok = 1'b0;
         if (av_b) icnt++;
      end
      chk("to_no_gnt", 64'(ok), 64'd1);
      chk("to_issue_cycles", 64'(icnt), 64'(TO_B));
      ready_b = 1'b1;

      // Drain scoreboards (bounded)
      for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
      chk("sb_a_drained", 64'(qa.size()), 64'd0);
      chk("sb_b_drained", 64'(qb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aos_arb.md
AOS_ARB -- requirements
Module: aos_arb

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
  NUM_REQ, 2, number of requesters sharing the aos datapath
  AOS_ADDR_WIDTH, 1, aos stream address width
  AXI_DATA_WIDTH, 32, data width
  RD_LATENCY, 1, cycles from aos handshake to valid aos rdata (>=1)
  TIMEOUT, 255, max ISSUE cycles without aos_ready_i before abort
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all logic rising-edge
  rst  in  1  asynchronous active-high reset
  req_i  in  NUM_REQ  per-requester request, held until gnt
  addr_i  in  NUM_REQ x AOS_ADDR_WIDTH  per-requester address
  wdata_i  in  NUM_REQ x AXI_DATA_WIDTH  per-requester write data
  gnt_o  out  NUM_REQ  one-cycle grant pulse at aos handshake
  rvalid_o  out  NUM_REQ  one-cycle response pulse to the owner
  rdata_o  out  AXI_DATA_WIDTH  response data, shared, qualified by rvalid_o
  err_o  out  1  one-cycle pulse on timeout abort, coincident with rvalid_o
  busy_o  out  1  high whenever FSM is not IDLE
  aos_valid_o  out  1  stream valid to aos_wrapper
  aos_addr_o  out  AOS_ADDR_WIDTH  stream address
  aos_wdata_o  out  AXI_DATA_WIDTH  stream write data
  aos_ready_i  in  1  stream ready from aos_wrapper
  aos_rdata_i  in  AXI_DATA_WIDTH  stream read data
REQ-003 Clock is clk; reset is rst, asynchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-005 IDLE: if any req_i set, winner = first set bit at or after rr_ptr (wrapping); latch winner index, addr_i, wdata_i; next ISSUE. No req: stay IDLE.
REQ-006 ISSUE: aos_valid_o=1, aos_addr_o/aos_wdata_o = latched values, stable until handshake.
REQ-007 Handshake = aos_valid_o & aos_ready_i; in that cycle gnt_o[winner]=1, latency counter loads RD_LATENCY, next WAIT.
REQ-008 WAIT: counter decrements each cycle; on cycle where counter==1 capture aos_rdata_i into rdata_o register; next RESP.
REQ-009 RESP: rvalid_o[winner]=1 for exactly one cycle; rr_ptr = (winner+1) mod NUM_REQ; next IDLE.
REQ-010 Request-to-response SHALL be RD_LATENCY+3 cycles minimum with aos_ready_i high (IDLE latch, ISSUE, WAIT..., RESP).
REQ-011 Timeout counter SHALL clear on entering ISSUE; on reaching TIMEOUT without handshake: aos_valid_o drops, no gnt_o, rdata_o=0, go RESP with err_o=1.
REQ-012 Once latched, transaction SHALL complete regardless of req_i deassertion; req_i dropped before latch is simply not seen.
REQ-013 Only one transaction outstanding; at most one gnt_o and one rvalid_o bit set per cycle.
REQ-014 aos_valid_o SHALL be 0 in IDLE, WAIT, RESP.
REQ-015 Round-robin: requester granted SHALL have lowest priority next arbitration; no starvation with continuous requests.

Reset
REQ-016 On rst: state=IDLE, rr_ptr=0, counters=0, all outputs 0 (gnt_o, rvalid_o, rdata_o, err_o, busy_o, aos_valid_o, aos_addr_o, aos_wdata_o).
REQ-017 Reset mid-transaction SHALL abandon it silently: no gnt_o/rvalid_o after release.

Structure
REQ-018 Package aos_arb_pkg SHALL hold the state enum and default parameter constants.
REQ-019 Sub-module aos_rr_pick (combinational: req vector + pointer -> one-hot winner + any) SHALL implement winner selection.

Verification
REQ-020 Single: req_i=01, addr=1, wdata=0xA5A5_0001, ready=1, rdata=0x1234 -> gnt_o[0] 2 cycles after req, rvalid_o[0] with rdata_o=0x1234 at RD_LATENCY+3.
REQ-021 Contention: req_i=11 held continuously -> grants alternate 0,1,0,1; no double grants.
REQ-022 Backpressure: ready low 10 cycles -> aos_valid_o, aos_addr_o, aos_wdata_o stable 10 cycles; gnt_o on cycle ready rises.
REQ-023 Timeout: TIMEOUT=8, ready held 0 -> after 8 ISSUE cycles err_o=1, rvalid_o[winner]=1, rdata_o=0, no gnt_o.
REQ-024 Reset in WAIT: rst pulse -> all outputs 0, no rvalid_o; next req_i=10 granted to requester 1 (rr_ptr=0 wraps).
REQ-025 RD_LATENCY=3: rdata_o equals aos_rdata_i sampled 3 cycles after handshake.
